// File: rtl/uart_pkg.sv
// UART shared definitions: receiver/transmitter state encoding and oversampling
// constants. Shared by uart_rx and the future uart_tx.
package uart_pkg;

    // Ticks per bit period at 16x oversampling
    localparam int OVERSAMPLE = 16;

    // Tick index at the middle of the start bit
    localparam int MID_START = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops load RST_VAL while reset is low.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two register stages give the first flop a full cycle to settle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, DBIT data bits, SB_TICK ticks of stop.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN; without it the
// PARITY state is never entered and parity_err is tied low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       parity_err
);

    // Tick counter is 4 bits unless the stop period needs more
    localparam int CNT_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    uart_state_e      state, state_nxt;
    logic [CNT_W-1:0] s_cnt, s_cnt_nxt;
    logic [2:0]       n, n_nxt;
    logic [7:0]       b, b_nxt;
    logic             done_nxt;
    logic             rx_s;
    logic [7:0]       data_rj;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Bits arrive LSB first into the MSB end, so DBIT shifts leave data top-aligned
    assign data_rj = b >> (8 - DBIT);

`ifdef UART_RX_PARITY_EN
    logic p, p_nxt;
`endif

    // Frame state, counters and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            s_cnt <= '0;
            n     <= '0;
            b     <= '0;
`ifdef UART_RX_PARITY_EN
            p     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            s_cnt <= s_cnt_nxt;
            n     <= n_nxt;
            b     <= b_nxt;
`ifdef UART_RX_PARITY_EN
            p     <= p_nxt;
`endif
        end
    end

    // Next-state logic: everything but start detection advances only on s_tick
    always_comb begin
        state_nxt = state;
        s_cnt_nxt = s_cnt;
        n_nxt     = n;
        b_nxt     = b;
        done_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_nxt     = p;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    s_cnt_nxt = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == CNT_W'(MID_START)) begin
                        // A line that is high again mid start bit was a glitch
                        if (!rx_s) begin
                            state_nxt = DATA;
                            s_cnt_nxt = '0;
                            n_nxt     = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == CNT_W'(OVERSAMPLE - 1)) begin
                        b_nxt     = {rx_s, b[7:1]};
                        s_cnt_nxt = '0;
                        n_nxt     = n + 1'b1;
                        if (n == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt == CNT_W'(OVERSAMPLE - 1)) begin
                        p_nxt     = rx_s;
                        s_cnt_nxt = '0;
                        state_nxt = STOP;
                    end else begin
                        s_cnt_nxt = s_cnt + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                // Line activity here is ignored; start detection resumes in IDLE
                if (s_tick) begin
                    if (s_cnt == CNT_W'(SB_TICK - 1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        s_cnt_nxt = s_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result registers: updated together with the done pulse, held between frames
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_tick <= 1'b0;
            dout         <= '0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= done_nxt;
            if (done_nxt) begin
                dout      <= data_rj;
                frame_err <= ~rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits and parity bit together must XOR to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (done_nxt) begin
            parity_err <= (^data_rj) ^ p;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic
// compared against a frame-level reference model. Honors UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clks

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rec_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    rec_t got_q[$];
    rec_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   wide_cnt  = 0;
    logic prev_done = 1'b0;

    uart_rx #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk out of every four
    initial begin : tickgen
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c = (c + 1) % 4;
            s_tick = (c == 0);
        end
    end

    // Capture every received frame; note any pulse longer than one clk
    always @(negedge clk) begin
        if (rx_done_tick) got_q.push_back(rec_t'({dout, frame_err, parity_err}));
        if (rx_done_tick && prev_done) wide_cnt <= wide_cnt + 1;
        prev_done <= rx_done_tick;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: what a correct receiver reports for a frame put on the wire
    function automatic rec_t model(input logic [7:0] data, input logic stop, input logic par);
        rec_t r;
        logic [7:0] m;
        m    = data & 8'((1 << DBIT) - 1);
        r.d  = m;
        r.fe = ~stop;
`ifdef UART_RX_PARITY_EN
        r.pe = (^m) ^ par;
`else
        r.pe = 1'b0;
`endif
        return r;
    endfunction

    // Drive one frame; a bad stop bit is held low only long enough to be sampled
    task automatic send(input logic [7:0] data, input logic stop, input logic par);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < DBIT; i++) begin
            rx = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rx = stop;
        if (stop) begin
            repeat (BIT_CLKS) @(negedge clk);
        end else begin
            repeat (40) @(negedge clk);
            rx = 1'b1;
        end
        exp_q.push_back(model(data, stop, par));
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        rec_t g;
        rec_t e;
        idle(2 * BIT_CLKS);
        chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, " dout"}, 32'(g.d), 32'(e.d));
            chk({tag, " frame_err"}, 32'(g.fe), 32'(e.fe));
            chk({tag, " parity_err"}, 32'(g.pe), 32'(e.pe));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin : stim
        logic [7:0] d;
        logic       st;
        logic       par;

        // Reset state
        reset = 1'b0;
        rx    = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset dout", 32'(dout), 32'h0);
        chk("reset done", 32'(rx_done_tick), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset parity_err", 32'(parity_err), 32'h0);
        reset = 1'b1;
        idle(20);

        // Plain good frame
        send(8'hA5, 1'b1, ^8'hA5);
        check_rx("a5");

        // Short low pulse must be rejected as a glitch
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check_rx("glitch");
        chk("glitch dout held", 32'(dout), 32'hA5);

        // Framing error still delivers data, cleared by the next good frame
        send(8'h3C, 1'b0, ^8'h3C);
        idle(BIT_CLKS);
        send(8'h01, 1'b1, ^8'h01);
        check_rx("ferr");

        // Back-to-back frames with a single stop bit and no gap
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        check_rx("b2b");

        // Reset in the middle of data bit 4 of 0x55
        d  = 8'h55;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = d[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset dout", 32'(dout), 32'h0);
        chk("midreset done", 32'(rx_done_tick), 32'h0);
        chk("midreset frame_err", 32'(frame_err), 32'h0);
        chk("midreset parity_err", 32'(parity_err), 32'h0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        idle(BIT_CLKS);
        send(8'h81, 1'b1, ^8'h81);
        check_rx("after reset");

`ifdef UART_RX_PARITY_EN
        // Even parity on 0x07 (three ones): parity bit 1 is correct, 0 is wrong
        send(8'h07, 1'b1, 1'b1);
        idle(BIT_CLKS);
        send(8'h07, 1'b1, 1'b0);
        check_rx("parity");
`endif

        // Randomized traffic in groups of five frames
        for (int grp = 0; grp < 4; grp++) begin
            for (int k = 0; k < 5; k++) begin
                d  = 8'($urandom_range(0, 255));
                st = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
                par = 1'($urandom_range(0, 1));
`else
                par = ^d;
`endif
                send(d, st, par);
                if (st) idle($urandom_range(0, 80));
                else    idle(BIT_CLKS + $urandom_range(0, 40));
            end
            check_rx("random");
        end

        chk("done pulse width", 32'(wide_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
